// File: rtl/aes_round_key_feeder.sv
// Captures an expanded AES key schedule on load and issues one round key per valid/ready transfer.
// Optional AES_KEY_ZEROIZE_EN clears the stored schedule after the final key and blanks round_key when idle.
module aes_round_key_feeder #(
    parameter int Nk = 8,
    parameter int Nr = Nk + 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     decrypt,
    input  logic [0:128*(Nr+1)-1]    expanded_key,
    output logic                     busy,
    output logic                     rk_valid,
    input  logic                     rk_ready,
    output logic [0:127]             round_key,
    output logic [3:0]               round_idx,
    output logic                     last,
    output logic                     done
);

    localparam int SW = $clog2(128 * (Nr + 1));
    localparam logic [3:0] IDX_LAST = 4'(Nr);

    // Handshake: a key moves on any cycle with rk_valid && rk_ready; while
    // rk_valid is high and rk_ready low, round_key/round_idx/last hold.
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [0:128*(Nr+1)-1]   key_store;
    logic                    dir;
    logic                    xfer;
    logic [SW-1:0]           base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_store <= '0;
            dir       <= 1'b0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= xfer && last;
            if (state == IDLE && load) begin
                key_store <= expanded_key;
                dir       <= decrypt;
                round_idx <= decrypt ? IDX_LAST : 4'd0;
            end else if (xfer && !last) begin
                round_idx <= dir ? round_idx - 4'd1 : round_idx + 4'd1;
            end
`ifdef AES_KEY_ZEROIZE_EN
            if (xfer && last) begin
                key_store <= '0;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        rk_valid  = 1'b0;
        busy      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                last     = dir ? (round_idx == 4'd0) : (round_idx == IDX_LAST);
                if (rk_ready && last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer = rk_valid && rk_ready;

    // Round k starts at bit 128*k of the flat schedule.
    assign base = SW'({round_idx, 7'b0});

    always_comb begin
        round_key = key_store[base +: 128];
`ifdef AES_KEY_ZEROIZE_EN
        if (!rk_valid) begin
            round_key = '0;
        end
`endif
    end

endmodule

// File: tb/tb_aes_round_key_feeder.sv
// Directed table-driven bench for aes_round_key_feeder using the AES-256 schedule of key 000102..1f.
module tb_aes_round_key_feeder;

    localparam int NR = 14;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load;
    logic                  decrypt;
    logic [0:128*(NR+1)-1] expanded_key;
    logic                  busy;
    logic                  rk_valid;
    logic                  rk_ready;
    logic [0:127]          round_key;
    logic [3:0]            round_idx;
    logic                  last;
    logic                  done;

    logic [0:128*(NR+1)-1] ek_main;
    logic [0:128*(NR+1)-1] ek_alt;
    logic [127:0]          sched [0:NR];

    int checks   = 0;
    int failures = 0;

    aes_round_key_feeder #(.Nk(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .decrypt      (decrypt),
        .expanded_key (expanded_key),
        .busy         (busy),
        .rk_valid     (rk_valid),
        .rk_ready     (rk_ready),
        .round_key    (round_key),
        .round_idx    (round_idx),
        .last         (last),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       dec;
        logic       rdy;
        logic       alt;
        logic       ev;
        logic [3:0] ei;
        logic       el;
        logic       ed;
        logic       kz;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ld, input logic dec, input logic rdy, input logic alt,
                                input logic ev, input logic [3:0] ei, input logic el,
                                input logic ed, input logic kz);
        vec_t v;
        v = '{ld, dec, rdy, alt, ev, ei, el, ed, kz};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_key(input vec_t v);
        if (v.kz) return '0;
`ifdef AES_KEY_ZEROIZE_EN
        if (!v.ev) return '0;
`endif
        return sched[v.ei];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int xf;
        int dn;
        int dn_at;
        int done_seen;

        sched[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        sched[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        sched[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        sched[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        sched[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        sched[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        sched[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        sched[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        sched[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        sched[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        sched[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        sched[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        sched[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        sched[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        sched[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        for (int k = 0; k <= NR; k++) begin
            ek_main[128*k +: 128] = sched[k];
            ek_alt[128*k +: 128]  = ~sched[k];
        end

        // Encrypt run with a 3-cycle stall at idx 5, schedule change and ignored load mid-run.
        add(1, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k <= 4; k++) add(0, 0, 1, 0, 1, 4'(k), 0, 0, 0);
        add(0, 0, 0, 0, 1, 5, 0, 0, 0);
        add(0, 0, 0, 1, 1, 5, 0, 0, 0);
        add(0, 0, 0, 0, 1, 5, 0, 0, 0);
        add(0, 0, 1, 0, 1, 5, 0, 0, 0);
        for (int k = 6; k <= 13; k++) add((k == 8), (k == 8), 1, (k == 8), 1, 4'(k), 0, 0, 0);
        add(0, 0, 1, 0, 1, 14, 1, 0, 0);
        // Done cycle: a decrypt load here is accepted.
        add(1, 1, 1, 0, 0, 14, 0, 1, 0);
        for (int k = 14; k >= 0; k--) add(0, 0, 1, 0, 1, 4'(k), (k == 0), 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        load = 1'b0;
        decrypt = 1'b0;
        rk_ready = 1'b0;
        expanded_key = ek_main;
        step();
        step();
        check("reset busy", 128'(busy), 128'd0);
        check("reset rk_valid", 128'(rk_valid), 128'd0);
        check("reset round_key", round_key, 128'd0);
        check("reset round_idx", 128'(round_idx), 128'd0);
        check("reset last", 128'(last), 128'd0);
        check("reset done", 128'(done), 128'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            load         = vecs[i].ld;
            decrypt      = vecs[i].dec;
            rk_ready     = vecs[i].rdy;
            expanded_key = vecs[i].alt ? ek_alt : ek_main;
            @(negedge clk);
            check($sformatf("row%0d rk_valid", i), 128'(rk_valid), 128'(vecs[i].ev));
            check($sformatf("row%0d busy", i), 128'(busy), 128'(vecs[i].ev));
            check($sformatf("row%0d round_idx", i), 128'(round_idx), 128'(vecs[i].ei));
            check($sformatf("row%0d last", i), 128'(last), 128'(vecs[i].el));
            check($sformatf("row%0d done", i), 128'(done), 128'(vecs[i].ed));
            check($sformatf("row%0d round_key", i), round_key, exp_key(vecs[i]));
            step();
        end
        load = 1'b0;
        expanded_key = ek_main;

        // Reset at idx 7 discards the run.
        decrypt = 1'b0;
        rk_ready = 1'b1;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (7) step();
        @(negedge clk);
        check("pre-reset idx", 128'(round_idx), 128'd7);
        check("pre-reset key", round_key, sched[7]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst rk_valid", 128'(rk_valid), 128'd0);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst round_idx", 128'(round_idx), 128'd0);
        check("midrst round_key", round_key, 128'd0);
        check("midrst last", 128'(last), 128'd0);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || rk_valid) done_seen++;
            step();
        end
        check("midrst no done", 128'(done_seen), 128'd0);

        // Fresh encrypt run: 15 transfers, done 16 cycles after load.
        load = 1'b1;
        step();
        load = 1'b0;
        xf = 0;
        dn = 0;
        dn_at = -1;
        for (int c = 1; c <= 40 && dn == 0; c++) begin
            @(negedge clk);
            if (c == 1) check("restart first idx", 128'(round_idx), 128'd0);
            if (rk_valid && rk_ready) begin
                if (round_idx !== 4'(xf) || round_key !== sched[xf]) begin
                    check($sformatf("restart xfer%0d key", xf), round_key, sched[xf]);
                end
                xf++;
            end
            if (done) begin
                dn++;
                dn_at = c;
            end
            step();
        end
        check("restart transfers", 128'(xf), 128'd15);
        check("restart done cycle", 128'(dn_at), 128'd16);

        @(negedge clk);
        check("idle done low", 128'(done), 128'd0);
`ifdef AES_KEY_ZEROIZE_EN
        check("zeroize round_key", round_key, 128'd0);
        check("zeroize key_store", 128'(dut.key_store == '0), 128'd1);
`else
        check("idle held key", round_key, sched[14]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_key_feeder.md
Name: aes_round_key_feeder

Overview:
- Sequential stage directly downstream of Key_Expansion. It captures the flat expanded key schedule on a load pulse and issues one 128-bit round key per transfer to the round datapath over a valid/ready handshake.
- Supports encrypt order (round 0..Nr) and decrypt order (round Nr..0).
- Decouples the wide combinational schedule from the iterative cipher core. The schedule input may change once the load has been accepted.

Parameters:
- Nk, 8, key length in 32-bit words (4/6/8 for AES-128/192/256).
- Nr, Nk+6, number of rounds; Nr+1 round keys are issued per run.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- load  input  1  start pulse; sampled only in IDLE
- decrypt  input  1  order select, sampled with load; 1 = reverse order
- expanded_key  input  [0:128*(Nr+1)-1]  schedule from Key_Expansion; round k occupies bits [128k : 128k+127]
- busy  output  1  high from the cycle after an accepted load until the final transfer cycle inclusive
- rk_valid  output  1  round_key/round_idx/last are valid
- rk_ready  input  1  consumer accepts the current key
- round_key  output  [0:127]  current round key
- round_idx  output  4  index k of the current round key
- last  output  1  high with the final key of a run
- done  output  1  one-cycle pulse the cycle after the final transfer

Behaviour:
- Reset values: busy=0, rk_valid=0, round_key=0, round_idx=0, last=0, done=0. Internal key_store=0 and state=IDLE.
- Reset mid-run: the run is discarded. Outputs take reset values on the next edge, and no done pulse is generated.
- FSM has two states, IDLE and ISSUE.
- IDLE + load=1:
  - key_store <= expanded_key; dir <= decrypt.
  - round_idx <= 0 (encrypt) or Nr (decrypt).
  - Next state is ISSUE.
- IDLE + load=0: remain in IDLE.
- ISSUE:
  - rk_valid=1 and busy=1.
  - round_key = key_store slice selected by round_idx.
  - last=1 when round_idx==Nr (encrypt) or round_idx==0 (decrypt).
- Transfer occurs on a cycle where rk_valid&&rk_ready.
  - Non-last transfer: round_idx steps +1 (encrypt) or -1 (decrypt) at the next edge.
  - Last transfer: next state is IDLE; rk_valid=0, busy=0, last=0 and done=1 on the following cycle.
- Latency: load at edge t gives rk_valid=1 in cycle t+1. With rk_ready held high, Nr+1 consecutive transfers occur, and done is asserted Nr+2 cycles after load.
- Backpressure: while rk_valid=1 and rk_ready=0, round_key, round_idx and last hold stable. rk_valid never drops without a transfer, except on reset.
- load while busy is ignored. It is not queued and key_store is unchanged.
- load in the done cycle is accepted, since state is IDLE then.
- Changes on expanded_key after the load edge have no effect on the current run.
- Without zeroization, round_idx and round_key hold their last values in IDLE.
- round_idx never wraps: the range is 0..Nr, and step direction is fixed per run.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- Defined:
  - At the final transfer edge, key_store is cleared to all zeros.
  - round_key is forced to 0 whenever rk_valid=0.
  - Reset also clears key_store.
  - No key material remains visible after done.
- Undefined:
  - key_store retains the last schedule until the next accepted load.
  - In IDLE, round_key shows the slice at the held round_idx.

Test Plan:
- Schedule: Nk=8, key 000102…1f expanded by Key_Expansion.
- Encrypt run: load, decrypt=0, rk_ready=1 ->
  - rk_valid rises 1 cycle after load.
  - idx0 key = 000102030405060708090a0b0c0d0e0f.
  - idx1 key = 101112131415161718191a1b1c1d1e1f.
  - idx14 key = 24fc79ccbf0979e9371ac23c6d68de36 with last=1.
  - done pulses once, 16 cycles after load.
- Decrypt run on the same schedule -> first key is 24fc79cc…6d68de36 at idx 14; last=1 with 000102…0f at idx 0; exactly 15 transfers.
- Backpressure: rk_ready=0 for 3 cycles at idx 5 -> round_key, idx=5 and last=0 are stable across all 3 cycles; idx 6 follows the first ready cycle.
- load pulsed mid-run with a different expanded_key -> ignored; remaining keys match the original schedule.
- Reset at idx 7 -> outputs zero on the next edge; no done pulse; a fresh load then restarts at idx 0.
- With AES_KEY_ZEROIZE_EN defined -> after the final transfer, round_key reads 0 in IDLE, and an internal key_store probe reads all zeros.
